// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction-cache controller, 64 sets x 64-byte lines.
// Latency: hit responds 2 cycles after the accept cycle; a miss first refills the line one byte per cycle.
// Backpressure: req_ready only in IDLE; mem request held until mem_req_ready; beats wait on mem_rready; no resp backpressure.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr fetch request handshake and byte address
//   resp_valid/resp_data        one-cycle response pulse with fetched word
//   flush                       invalidate all lines (fence.i)
//   mem_req_*                   line-fill request to the memory bus
//   mem_rvalid/mem_rready/mem_rdata  64-bit little-endian fill beats
//   ram_*                       byte-organised data RAM (write port + combinational word read)
module icache_ctrl #(
  parameter int TAG_W = 20,
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [63:0] mem_rdata,
  output logic        ram_wen,
  output logic [5:0]  ram_index,
  output logic [5:0]  ram_offset,
  output logic [5:0]  ram_w_offset,
  output logic [7:0]  ram_data_in,
  input  logic [31:0] ram_data_out
);

  // Beat and byte counters are 3 bits each so {beat,byte} spans the 64-byte line.
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_FILL_WAIT,
    S_FILL_WRITE
  } state_e;

  state_e            state_q, state_d;
  logic              alive_q;       // low during reset and until the first clock after release
  logic [31:2]       addr_q;        // latched word address of the current fetch
  logic [63:0]       valid_q;
  logic [TAG_W-1:0]  tag_q [64];
  logic [2:0]        beat_q;
  logic [2:0]        byte_q;
  logic [63:0]       buf_q;         // beat currently being written into the RAM
  logic              flush_pend_q;  // flush seen outside IDLE, applied on the next IDLE cycle
  logic              resp_valid_q;
  logic [31:0]       resp_data_q;

  logic [5:0]        cur_index;
  logic [TAG_W-1:0]  cur_tag;
  logic              hit;
  logic              accept;
  logic              flush_now;
  logic              last_byte;
  logic              fill_done;
  logic              unused_addr_lsbs;

  assign cur_index = addr_q[11:6];
  assign cur_tag   = addr_q[31:32-TAG_W];
  assign hit       = valid_q[cur_index] && (tag_q[cur_index] == cur_tag);
  assign accept    = req_valid && req_ready;
  assign flush_now = (state_q == S_IDLE) && (flush || flush_pend_q);
  assign last_byte = (byte_q == 3'd7);
  assign fill_done = (state_q == S_FILL_WRITE) && last_byte && (beat_q == LAST_BEAT);

  // Fetches are word granular; the byte-in-word bits carry no information.
  assign unused_addr_lsbs = ^req_addr[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = S_LOOKUP;
      S_LOOKUP:     state_d = hit ? S_IDLE : S_MISS_REQ;
      S_MISS_REQ:   if (mem_req_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT:  if (mem_rvalid) state_d = S_FILL_WRITE;
      S_FILL_WRITE: begin
        if (last_byte) begin
          // The final byte completes the line; re-lookup to produce the response.
          state_d = (beat_q == LAST_BEAT) ? S_LOOKUP : S_FILL_WAIT;
        end
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_rready    = 1'b0;
    ram_wen       = 1'b0;
    case (state_q)
      // A pending or live flush takes the IDLE cycle, so no request is accepted in it.
      S_IDLE:       req_ready = alive_q && !flush && !flush_pend_q;
      S_MISS_REQ:   mem_req_valid = 1'b1;
      S_FILL_WAIT:  mem_rready = 1'b1;
      S_FILL_WRITE: ram_wen = 1'b1;
      default:      ;
    endcase
  end

  assign mem_req_addr = {addr_q[31:6], 6'b0};
  assign ram_index    = cur_index;
  assign ram_offset   = {addr_q[5:2], 2'b00};
  assign ram_w_offset = {beat_q, byte_q};
  assign ram_data_in  = buf_q[{byte_q, 3'b000} +: 8];
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      addr_q       <= '0;
      valid_q      <= '0;
      beat_q       <= '0;
      byte_q       <= '0;
      buf_q        <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      alive_q <= 1'b1;

      if (accept) begin
        addr_q <= req_addr[31:2];
      end

      resp_valid_q <= (state_q == S_LOOKUP) && hit;
      if ((state_q == S_LOOKUP) && hit) begin
        resp_data_q <= ram_data_out;
      end

      if (state_q == S_IDLE) begin
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end

      // Invalidate on miss so a half-written line can never hit; set only once complete.
      if (flush_now) begin
        valid_q <= '0;
      end else if ((state_q == S_LOOKUP) && !hit) begin
        valid_q[cur_index] <= 1'b0;
      end else if (fill_done) begin
        valid_q[cur_index] <= 1'b1;
      end

      if ((state_q == S_MISS_REQ) && mem_req_ready) begin
        beat_q <= '0;
      end else if ((state_q == S_FILL_WRITE) && last_byte) begin
        beat_q <= beat_q + 3'd1;
      end

      if ((state_q == S_FILL_WAIT) && mem_rvalid) begin
        buf_q  <= mem_rdata;
        byte_q <= '0;
      end else if (state_q == S_FILL_WRITE) begin
        byte_q <= byte_q + 3'd1;
      end
    end
  end

  // Tag array needs no reset: every entry is qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[cur_index] <= cur_tag;
    end
  end

endmodule
